io_sink_serializer: RTL and testbench

IO_SINK_SERIALIZER -- requirements
Module: io_sink_serializer

---
 rtl/io_sink_serializer.sv | 148 ++++++++++++++
 tb/tb_io_sink_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_sink_serializer.sv
// Captures CPU write-back words into a FIFO and streams each one out as four bytes, LSB first.
// Optional build macro IO_SINK_DROP_COUNT_EN adds a saturating dropped-word counter on dropCount.
module io_sink_serializer #(
    parameter int DATAWIDTH = 25,
    parameter int DEPTH     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     outFlag,
    input  logic [DATAWIDTH-1:0]     dataIn,
    output logic [7:0]               byteOut,
    output logic                     byteValid,
    input  logic                     byteReady,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               dropCount
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int PADW = (DATAWIDTH > 32) ? DATAWIDTH : 32;

    typedef enum logic {
        IDLE,
        SEND
    } serState;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    serState              state;
    logic [1:0]           idx;
    logic [PADW-1:0]      shiftReg;
    logic [PADW-1:0]      headWord;
    logic                 xfer;
    logic                 lastByte;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop feeds the serializer: either it is idle, or it is finishing byte 3 this edge.
    assign xfer     = (state == SEND) && byteReady;
    assign lastByte = xfer && (idx == 2'd3);
    assign pop      = !empty && ((state == IDLE) || lastByte);
    assign push     = outFlag && (!full || pop);
    assign drop     = outFlag && full && !pop;

    // Zero-extension makes bytes above DATAWIDTH read as 0.
    assign headWord = PADW'(mem[rdPtr]);

    // NOTE: the storage array has no reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= dataIn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            shiftReg  <= '0;
            byteOut   <= 8'h00;
            byteValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shiftReg  <= headWord;
                        byteOut   <= headWord[7:0];
                        idx       <= 2'd0;
                        byteValid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx != 2'd3) begin
                            shiftReg <= shiftReg >> 8;
                            byteOut  <= shiftReg[15:8];
                            idx      <= idx + 2'd1;
                        end else if (pop) begin
                            shiftReg <= headWord;
                            byteOut  <= headWord[7:0];
                            idx      <= 2'd0;
                        end else begin
                            byteOut   <= 8'h00;
                            idx       <= 2'd0;
                            byteValid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    byteValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_SINK_DROP_COUNT_EN
    logic [7:0] dropCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dropCnt <= 8'h00;
        end else if (drop && (dropCnt != 8'hFF)) begin
            dropCnt <= dropCnt + 8'h01;
        end
    end

    assign dropCount = dropCnt;
`else
    assign dropCount = 8'h00;
`endif

endmodule

// File: tb/tb_io_sink_serializer.sv
// Scoreboard bench: expected bytes are queued at push time and a negedge monitor checks every transfer.
module tb_io_sink_serializer;

    logic        clock;
    logic        reset;
    logic        outFlag;
    logic [24:0] dataIn;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        byteReady;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  dropCount;

    int total = 0;
    int bad   = 0;
    logic [7:0] expQ [$];

    logic [24:0] vec [0:10] = '{
        25'h0123456, 25'h1FEDCBA, 25'h0A5A5A5, 25'h1000001, 25'h0FF00FF,
        25'h1234567, 25'h0765432, 25'h1111111, 25'h0ABCDEF, 25'h1DEAD00,
        25'h0BEEF12
    };

    io_sink_serializer #(.DATAWIDTH(25), .DEPTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .outFlag   (outFlag),
        .dataIn    (dataIn),
        .byteOut   (byteOut),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .dropCount (dropCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bytes go out LSB first; bits 31:25 are zero for a 25-bit word.
    task automatic expectWord(input logic [24:0] w);
        logic [31:0] p;
        p = {7'b0, w};
        expQ.push_back(p[7:0]);
        expQ.push_back(p[15:8]);
        expQ.push_back(p[23:16]);
        expQ.push_back(p[31:24]);
    endtask

    always @(negedge clock) begin
        if (reset && byteValid && byteReady) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_byte got=%0h want=none", byteOut);
            end else begin
                check("byte_stream", {24'h0, byteOut}, {24'h0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] heldByte;
        reset     = 1'b0;
        outFlag   = 1'b0;
        dataIn    = '0;
        byteReady = 1'b1;
        #2;
        check("rst_valid",    {31'h0, byteValid}, 32'h0);
        check("rst_byte",     {24'h0, byteOut},   32'h0);
        check("rst_empty",    {31'h0, empty},     32'h1);
        check("rst_full",     {31'h0, full},      32'h0);
        check("rst_count",    {28'h0, count},     32'h0);
        check("rst_overflow", {31'h0, overflow},  32'h0);
        check("rst_drop",     {24'h0, dropCount}, 32'h0);
        #10;
        reset = 1'b1;

        // Single word: byte 0 visible after the edge following the push.
        outFlag = 1'b1;
        dataIn  = 25'h1ABCDEF;
        expectWord(25'h1ABCDEF);
        tick();
        outFlag = 1'b0;
        check("lat_count1",  {28'h0, count},     32'h1);
        check("lat_idle",    {31'h0, byteValid}, 32'h0);
        tick();
        check("lat_valid",   {31'h0, byteValid}, 32'h1);
        check("lat_b0",      {24'h0, byteOut},   32'hEF);
        tick();
        check("lat_b1",      {24'h0, byteOut},   32'hCD);
        tick();
        check("lat_b2",      {24'h0, byteOut},   32'hAB);
        tick();
        check("lat_b3",      {24'h0, byteOut},   32'h01);
        tick();
        check("lat_drop_valid", {31'h0, byteValid}, 32'h0);
        check("lat_empty",   {31'h0, empty},     32'h1);

        // Three words back to back: 12 bytes without a bubble.
        for (int i = 0; i < 3; i++) begin
            outFlag = 1'b1;
            dataIn  = vec[i];
            expectWord(vec[i]);
            tick();
        end
        outFlag = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check("b2b_valid", {31'h0, byteValid}, 32'h1);
            tick();
        end
        check("b2b_idle",  {31'h0, byteValid}, 32'h0);
        check("b2b_empty", {31'h0, empty},     32'h1);

        // Fill with the consumer stalled: one word in the shifter, eight in the FIFO.
        byteReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            outFlag = 1'b1;
            dataIn  = vec[i];
            expectWord(vec[i]);
            tick();
        end
        check("fill_count",    {28'h0, count},    32'h8);
        check("fill_full",     {31'h0, full},     32'h1);
        check("fill_overflow", {31'h0, overflow}, 32'h0);
        dataIn = vec[9];
        tick();
        outFlag = 1'b0;
        check("drop_overflow", {31'h0, overflow}, 32'h1);
        check("drop_count",    {28'h0, count},    32'h8);
`ifdef IO_SINK_DROP_COUNT_EN
        check("drop_counter",  {24'h0, dropCount}, 32'h1);
`else
        check("drop_counter",  {24'h0, dropCount}, 32'h0);
`endif

        // Full FIFO: push lands on the same edge as the pop after byte 3.
        byteReady = 1'b1;
        tick();
        tick();
        tick();
        outFlag = 1'b1;
        dataIn  = vec[10];
        expectWord(vec[10]);
        tick();
        outFlag   = 1'b0;
        byteReady = 1'b0;
        check("same_edge_count",    {28'h0, count},    32'h8);
        check("same_edge_full",     {31'h0, full},     32'h1);
        check("same_edge_overflow", {31'h0, overflow}, 32'h1);
        check("same_edge_b0",       {24'h0, byteOut},  {24'h0, vec[1][7:0]});

        // Ready pattern 1,0,0,1 in the middle of a word.
        byteReady = 1'b1;
        tick();
        byteReady = 1'b0;
        heldByte  = vec[1][15:8];
        check("stall_b1_a", {24'h0, byteOut}, {24'h0, heldByte});
        tick();
        check("stall_b1_b", {24'h0, byteOut}, {24'h0, heldByte});
        tick();
        check("stall_b1_c", {24'h0, byteOut}, {24'h0, heldByte});
        byteReady = 1'b1;
        tick();
        byteReady = 1'b0;
        check("stall_b2",   {24'h0, byteOut}, {24'h0, vec[1][23:16]});

        // Asynchronous reset between edges with words queued.
        #2;
        reset = 1'b0;
        #1;
        expQ.delete();
        check("arst_valid",    {31'h0, byteValid}, 32'h0);
        check("arst_byte",     {24'h0, byteOut},   32'h0);
        check("arst_count",    {28'h0, count},     32'h0);
        check("arst_empty",    {31'h0, empty},     32'h1);
        check("arst_full",     {31'h0, full},      32'h0);
        check("arst_overflow", {31'h0, overflow},  32'h0);
        check("arst_drop",     {24'h0, dropCount}, 32'h0);
        tick();
        #3;
        reset     = 1'b1;
        byteReady = 1'b1;
        outFlag   = 1'b1;
        dataIn    = 25'h0C0FFEE;
        expectWord(25'h0C0FFEE);
        tick();
        outFlag = 1'b0;
        check("post_rst_count", {28'h0, count},     32'h1);
        tick();
        check("post_rst_valid", {31'h0, byteValid}, 32'h1);
        check("post_rst_b0",    {24'h0, byteOut},   32'hEE);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("post_rst_idle",  {31'h0, byteValid}, 32'h0);
        check("sb_drained",     expQ.size(),        32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
